reg_file_mp: RTL

//  Parametrised multi-port register file for the execute pipeline: NUM_RD read ports, NUM_WR write ports.

---
 rtl/reg_file_mp_pkg.sv | 21 ++
 rtl/reg_file_mp_if.sv | 40 ++++
 rtl/reg_file_rd_port.sv | 83 ++++++++
 rtl/reg_file_mp.sv | 119 +++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared defaults and address-acceptance helper for the multi-port register file.
// Latency: n/a (compile-time constants and a pure function).
// Backpressure: n/a.
package reg_file_mp_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_LEN = 5;

    // An address names a real, writable register: in range and not the
    // hardwired zero register (when that option is on). Reads, writes and
    // scoreboard sets all use this single rule.
    function automatic logic reg_accept(
        input logic [31:0] addr,
        input int          num_regs,
        input logic        zero_reg
    );
        return (addr < 32'(num_regs)) && !(zero_reg && (addr == 32'd0));
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Register-file bus: decode-side reads and scoreboard sets, writeback-side writes.
// Latency: n/a (signal bundle only).
// Backpressure: none; the register file accepts every request every cycle.
//   master : decode/writeback side, drives requests and observes results
//   slave  : register file, consumes requests and drives rd_* and busy_vec
interface reg_file_mp_if
    import reg_file_mp_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_LEN = DEF_ADDR_LEN,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1
) ();

    logic [NUM_RD-1:0]          rd_en;
    logic [NUM_RD*ADDR_LEN-1:0] rd_addr;
    logic [NUM_RD*WIDTH-1:0]    rd_data;
    logic [NUM_RD-1:0]          rd_valid;
    logic [NUM_RD-1:0]          rd_busy;

    logic [NUM_WR-1:0]          wr_en;
    logic [NUM_WR*ADDR_LEN-1:0] wr_addr;
    logic [NUM_WR*WIDTH-1:0]    wr_data;

    logic                       sb_set;
    logic [ADDR_LEN-1:0]        sb_addr;
    logic [NUM_REGS-1:0]        busy_vec;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr,
        input  rd_data, rd_valid, rd_busy, busy_vec
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr,
        output rd_data, rd_valid, rd_busy, busy_vec
    );

endinterface

// File: rtl/reg_file_rd_port.sv
// One registered read port: address decode, storage mux, write bypass, output regs.
// Latency: 1 cycle from rd_en to rd_valid/rd_data/rd_busy.
// Backpressure: none; a request is served every cycle, idle cycles hold data/busy.
//   in : clk, rst_n, rd_en, rd_addr, mem (storage), busy (scoreboard),
//        wr_acc/wr_addr/wr_data (this cycle's accepted writes)
//   out: rd_data, rd_valid, rd_busy
module reg_file_rd_port
    import reg_file_mp_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_LEN = DEF_ADDR_LEN,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rd_en,
    input  logic [ADDR_LEN-1:0]        rd_addr,
    input  logic [WIDTH-1:0]           mem [NUM_REGS],
    input  logic [NUM_REGS-1:0]        busy,
    input  logic [NUM_WR-1:0]          wr_acc,
    input  logic [NUM_WR*ADDR_LEN-1:0] wr_addr,
    input  logic [NUM_WR*WIDTH-1:0]    wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       rd_busy
);

    logic             addr_ok;
    logic [WIDTH-1:0] arr_data;
    logic             arr_busy;
    logic             byp_hit;
    logic [WIDTH-1:0] byp_data;
    logic [WIDTH-1:0] nxt_data;
    logic             nxt_busy;

    always_comb begin
        addr_ok  = reg_accept(32'(rd_addr), NUM_REGS, ZERO_REG != 0);
        arr_data = '0;
        arr_busy = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(rd_addr) == 32'(i)) begin
                arr_data = mem[i];
                arr_busy = busy[i];
            end
        end

        // Ascending scan so the highest-indexed matching write port wins,
        // matching the priority used when the storage is updated.
        byp_hit  = 1'b0;
        byp_data = '0;
        if (BYPASS != 0) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_acc[w] && (wr_addr[w*ADDR_LEN +: ADDR_LEN] == rd_addr)) begin
                    byp_hit  = 1'b1;
                    byp_data = wr_data[w*WIDTH +: WIDTH];
                end
            end
        end

        // A forwarded write is also the writeback that clears the busy bit,
        // so a bypassed read reports not-busy. Same-cycle sb_set is not visible.
        nxt_data = !addr_ok ? '0 : (byp_hit ? byp_data : arr_data);
        nxt_busy = addr_ok && !byp_hit && arr_busy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_busy  <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= nxt_data;
                rd_busy <= nxt_busy;
            end
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with per-register busy scoreboard for hazard detection.
// Latency: reads 1 cycle; writes and scoreboard updates visible after the next edge.
// Backpressure: none; all read, write and sb_set requests are accepted every cycle.
//   in : clk, rst_n, bus (slave modport: rd_en/rd_addr, wr_en/wr_addr/wr_data, sb_set/sb_addr)
//   out: bus.rd_data/rd_valid/rd_busy (registered), bus.busy_vec (registered scoreboard)
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_LEN = DEF_ADDR_LEN,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_mp_if.slave  bus
);

    logic [WIDTH-1:0]        mem [NUM_REGS];
    logic [NUM_REGS-1:0]     busy_q;

    logic [NUM_WR-1:0]       wr_acc;
    logic [NUM_REGS-1:0]     reg_we;
    logic [WIDTH-1:0]        reg_wd [NUM_REGS];
    logic                    sb_ok;
    logic [NUM_REGS-1:0]     sb_set_vec;

    logic [NUM_RD*WIDTH-1:0] rd_data_w;
    logic [NUM_RD-1:0]       rd_valid_w;
    logic [NUM_RD-1:0]       rd_busy_w;

    // Write acceptance: out-of-range and zero-register writes are dropped here,
    // so they neither update storage nor clear a busy bit.
    always_comb begin
        for (int w = 0; w < NUM_WR; w++) begin
            wr_acc[w] = bus.wr_en[w] &&
                        reg_accept(32'(bus.wr_addr[w*ADDR_LEN +: ADDR_LEN]), NUM_REGS, ZERO_REG != 0);
        end
    end

    // Per-register write resolve; later ports overwrite earlier ones.
    always_comb begin
        reg_we = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_wd[i] = '0;
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_acc[w] && (32'(bus.wr_addr[w*ADDR_LEN +: ADDR_LEN]) == 32'(i))) begin
                    reg_we[i] = 1'b1;
                    reg_wd[i] = bus.wr_data[w*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        sb_ok = bus.sb_set && reg_accept(32'(bus.sb_addr), NUM_REGS, ZERO_REG != 0);
        for (int i = 0; i < NUM_REGS; i++) begin
            sb_set_vec[i] = sb_ok && (32'(bus.sb_addr) == 32'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_we[i]) begin
                    mem[i] <= reg_wd[i];
                end
            end
        end
    end

    // Clear from writeback is applied first so a same-cycle issue keeps the
    // register pending (the new producer has not written back yet).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~reg_we) | sb_set_vec;
        end
    end

    assign bus.busy_vec = busy_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        reg_file_rd_port #(
            .WIDTH    (WIDTH),
            .NUM_REGS (NUM_REGS),
            .ADDR_LEN (ADDR_LEN),
            .NUM_WR   (NUM_WR),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .clk      (clk),
            .rst_n    (rst_n),
            .rd_en    (bus.rd_en[p]),
            .rd_addr  (bus.rd_addr[p*ADDR_LEN +: ADDR_LEN]),
            .mem      (mem),
            .busy     (busy_q),
            .wr_acc   (wr_acc),
            .wr_addr  (bus.wr_addr),
            .wr_data  (bus.wr_data),
            .rd_data  (rd_data_w[p*WIDTH +: WIDTH]),
            .rd_valid (rd_valid_w[p]),
            .rd_busy  (rd_busy_w[p])
        );
    end

    assign bus.rd_data  = rd_data_w;
    assign bus.rd_valid = rd_valid_w;
    assign bus.rd_busy  = rd_busy_w;

endmodule
